mem_copy_engine: RTL

- Initiator-side block for the word-addressed data memory interface: 32-bit byte address, combinational read data, write on the rising clock edge when write enable is high, word index = address/4.
- On a start pulse, copies a block of 32-bit words from a source byte address to a destination byte address through that interface.
- Reports completion with a done pulse. Also reports misaligned requests.
- Sits between the control logic and the data memory port, as a DMA-style helper for block moves and stack copies.

---
 rtl/mem_copy_engine.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: DMA-style word copier on the data memory port.
// Copies word_count 32-bit words from src_addr to dst_addr, one READ cycle
// followed by one WRITE cycle per word, strictly forward. Misaligned
// requests are rejected with a one-cycle error pulse.
module mem_copy_engine #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            src_addr,
  input  logic [31:0]            dst_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [31:0]            mem_address,
  output logic                   mem_write_enable,
  output logic [31:0]            mem_write_data,
  input  logic [31:0]            mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t                 r_state;
  logic [31:0]            r_src_ptr;
  logic [31:0]            r_dst_ptr;
  logic [COUNT_WIDTH-1:0] r_remaining;
  logic [31:0]            r_data_latch;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;

  logic w_misaligned;
  assign w_misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);

  // Control FSM: owns pointers, counter, data latch and the status flags,
  // which are set alongside the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_src_ptr    <= '0;
      r_dst_ptr    <= '0;
      r_remaining  <= '0;
      r_data_latch <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (w_misaligned) begin
              // Reject without latching anything.
              r_state <= S_ERR;
              r_error <= 1'b1;
            end else if (word_count == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_src_ptr   <= src_addr;
              r_dst_ptr   <= dst_addr;
              r_remaining <= word_count;
              r_state     <= S_READ;
            end
          end
        end
        S_READ: begin
          r_data_latch <= mem_read_data;
          r_state      <= S_WRITE;
        end
        S_WRITE: begin
          // Pointers wrap silently at 2^32.
          r_src_ptr   <= r_src_ptr + 32'd4;
          r_dst_ptr   <= r_dst_ptr + 32'd4;
          r_remaining <= r_remaining - 1'b1;
          if (r_remaining == COUNT_WIDTH'(1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_READ;
          end
        end
        S_DONE, S_ERR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Memory port decode: address and strobe follow state combinationally
  // so the memory sees the write on the edge that leaves WRITE.
  always_comb begin
    mem_address      = 32'd0;
    mem_write_enable = 1'b0;
    case (r_state)
      S_READ:  mem_address = r_src_ptr;
      S_WRITE: begin
        mem_address      = r_dst_ptr;
        mem_write_enable = 1'b1;
      end
      default: mem_address = 32'd0;
    endcase
  end

  assign mem_write_data = r_data_latch;
  assign busy           = r_busy;
  assign done           = r_done;
  assign error          = r_error;

endmodule
